rr_scan4: RTL and testbench
===========================

RR_SCAN4 -- requirements
Module: rr_scan4

Interface
REQ-001 Parameter HOLD_MAX, default 4, meaning maximum accepted beats per grant before rotation; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_in  input  4  per-channel request; bit i high means channel i has data.
REQ-005 data_in  input  4  per-channel data bits; bit i is channel i's current value.
REQ-006 ready_in  input  1  downstream accepts the current beat this cycle.
REQ-007 sel_out  output  2  registered index of the granted channel, for driving a 4:1 mux select.
REQ-008 grant_out  output  4  registered one-hot grant; all-zero when no grant.
REQ-009 valid_out  output  1  registered; high only in SERVE.
REQ-010 y_out  output  1  data_in[sel_out] when valid_out=1, else 0 (combinational from data_in).

Function
REQ-011 The FSM SHALL have states IDLE, ARB and SERVE, encoded in 2 bits.
REQ-012 A transfer SHALL occur on a rising edge where valid_out=1 and ready_in=1.
REQ-013 IDLE: valid_out=0, grant_out=0000; go to ARB when req_in != 0000, else stay.
REQ-014 ARB (exactly one cycle): search channels ptr, ptr+1, ptr+2, ptr+3 (mod 4), take the first with req_in high; load sel_out and grant_out, clear beat count, go to SERVE.
REQ-015 ARB with req_in=0000 SHALL return to IDLE, with grant_out=0000 and ptr unchanged.
REQ-016 SERVE: valid_out=1; the beat counter (4 bits) SHALL increment by 1 on each transfer.
REQ-017 SERVE SHALL go to ARB when a transfer brings the beat count to HOLD_MAX, or when req_in[sel_out]=0 at the clock edge, whichever occurs first.
REQ-018 req_in[sel_out]=0 and a transfer on the same edge: the transfer SHALL count, then exit to ARB.
REQ-019 On every exit from SERVE, ptr SHALL become (sel_out+1) mod 4.
REQ-020 On every exit from SERVE, grant_out SHALL clear to 0000 and valid_out SHALL drop in ARB.
REQ-021 ready_in=0 in SERVE SHALL hold the state and count indefinitely; there is no timeout.
REQ-022 Latency: a request sampled in IDLE at edge k SHALL produce ARB after edge k and valid_out=1 after edge k+1.
REQ-023 Fairness: with all four channels requesting continuously, grants SHALL rotate 0,1,2,3,0,... with HOLD_MAX beats each.
REQ-024 Each ARB-to-SERVE switch SHALL cost exactly one bubble cycle.
REQ-025 sel_out SHALL retain its last value while in IDLE or ARB.
REQ-026 The beat counter SHALL saturate logically at HOLD_MAX and never wrap inside SERVE.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, ptr=0, sel_out=00, grant_out=0000, valid_out=0, beat count=0, y_out=0, independent of clk.
REQ-028 Reset asserted mid-SERVE SHALL abort the grant with no further transfer counted.
REQ-029 After deassertion, the first ARB SHALL search from channel 0.

Verification
REQ-030 Reset, then req_in=0100, ready_in=1, data_in=0100 -> ARB after 1 edge; then sel_out=10, grant_out=0100, valid_out=1, y_out=1; after 4 transfers, ARB, then SERVE again on channel 2.
REQ-031 req_in=1111, ready_in=1, HOLD_MAX=4 -> grant_out sequence 0001,0010,0100,1000,0001, each held 4 cycles, separated by one valid_out=0 cycle.
REQ-032 Channel 1 granted with ready_in=0 for 20 cycles -> valid_out stays 1, sel_out=01, no rotation; after ready_in=1, exactly 4 transfers occur.
REQ-033 Channel 3 granted, req_in[3] drops after 2 transfers -> ARB next; with req_in=0001 the next grant is channel 0 (ptr=0 via wrap).
REQ-034 rst_n pulsed low mid-SERVE between clock edges -> all outputs zero immediately; after release with req_in=1010, the first grant is channel 1.
REQ-035 Simultaneous req_in[sel_out] drop and transfer on the same edge -> count increments, FSM in ARB next cycle, ptr=sel_out+1.

Source files
------------

// File: rtl/rr_scan4.sv
// ----------------------------------------------------------------------------
// rr_scan4
//
// Round-robin scanning arbiter for four request channels. It grants one
// channel at a time. The granted channel streams single-bit beats downstream
// under a valid/ready handshake. The grant moves on when either of these
// happens:
//   - the channel has delivered HOLD_MAX beats, or
//   - the channel drops its request.
// Each new grant is chosen by a one-cycle arbitration step. That step scans
// forward from the channel after the last one served, so all channels get a
// fair share.
//
// States:
//   IDLE  : nothing requested, outputs quiet
//   ARB   : one-cycle bubble where the next channel is picked
//   SERVE : grant held, valid_out high, beats counted on each transfer
//
// Parameters:
//   HOLD_MAX   maximum beats accepted per grant before rotation (1..15)
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   req_in     in   [3:0] per-channel request
//   data_in    in   [3:0] per-channel current data bit
//   ready_in   in   downstream accepts the current beat
//   sel_out    out  [1:0] registered index of the granted channel
//   grant_out  out  [3:0] registered one-hot grant, zero when no grant
//   valid_out  out  registered, high only while serving
//   y_out      out  data bit of the granted channel while valid, else 0
// ----------------------------------------------------------------------------
module rr_scan4 #(
   parameter int HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req_in,
   input  logic [3:0] data_in,
   input  logic       ready_in,
   output logic [1:0] sel_out,
   output logic [3:0] grant_out,
   output logic       valid_out,
   output logic       y_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARB   = 2'd1;
   localparam logic [1:0] S_SERVE = 2'd2;

   // An out-of-range HOLD_MAX is pulled into 1..15. This keeps the 4-bit beat
   // counter from ever needing a value it cannot hold.
   localparam int HOLD_CLAMP = (HOLD_MAX < 1)  ? 1  :
                               (HOLD_MAX > 15) ? 15 : HOLD_MAX;
   localparam logic [3:0] HOLD_LIM = 4'(HOLD_CLAMP);

   logic [1:0] r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_sel;
   logic [3:0] r_grant;
   logic       r_valid;
   logic [3:0] r_beatCount;

   logic       w_anyReq;
   logic [1:0] w_cand;
   logic [1:0] w_pickIdx;
   logic [3:0] w_pickOneHot;
   logic       w_xfer;
   logic [3:0] w_beatInc;
   logic       w_holdDone;
   logic       w_reqLost;
   logic       w_serveExit;

   assign w_anyReq = |req_in;

   // Scan the four channels starting at the rotation pointer. The loop runs
   // from the farthest offset back to the pointer itself. Each later hit
   // overwrites an earlier one, so the hit nearest to the pointer is kept.
   // When nothing is requested, the pick is unused.
   always_comb begin
      w_cand    = r_ptr;
      w_pickIdx = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_cand = r_ptr + 2'(k);
         if (req_in[w_cand]) begin
            w_pickIdx = w_cand;
         end
      end
   end

   assign w_pickOneHot = 4'b0001 << w_pickIdx;

   // A beat moves only while serving and the sink is ready. The counter is
   // held at the limit instead of wrapping. This is a safety net: reaching
   // the limit always forces an exit on the same edge.
   assign w_xfer     = r_valid & ready_in;
   assign w_beatInc  = (r_beatCount == HOLD_LIM) ? r_beatCount
                                                 : r_beatCount + 4'd1;
   assign w_holdDone = w_xfer && (w_beatInc == HOLD_LIM);
   assign w_reqLost  = ~req_in[r_sel];
   assign w_serveExit = w_holdDone | w_reqLost;

   // State sequencing. IDLE waits for any request. ARB always lasts one
   // cycle: it either loads a new grant or falls back to IDLE with the
   // pointer untouched. SERVE counts transfers. A transfer on the exit edge
   // still counts, even when the request drops on that edge. Every exit
   // advances the pointer past the channel just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= 2'd0;
         r_sel       <= 2'd0;
         r_grant     <= 4'b0000;
         r_valid     <= 1'b0;
         r_beatCount <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_grant <= 4'b0000;
               r_valid <= 1'b0;
               if (w_anyReq) begin
                  r_state <= S_ARB;
               end
            end
            S_ARB: begin
               if (w_anyReq) begin
                  r_state     <= S_SERVE;
                  r_sel       <= w_pickIdx;
                  r_grant     <= w_pickOneHot;
                  r_valid     <= 1'b1;
                  r_beatCount <= 4'd0;
               end else begin
                  r_state <= S_IDLE;
                  r_grant <= 4'b0000;
                  r_valid <= 1'b0;
               end
            end
            S_SERVE: begin
               if (w_xfer) begin
                  r_beatCount <= w_beatInc;
               end
               if (w_serveExit) begin
                  r_state <= S_ARB;
                  r_ptr   <= r_sel + 2'd1;
                  r_grant <= 4'b0000;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= 4'b0000;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // The data path is a plain 4:1 mux driven by the registered select. It is
   // gated by valid, so y_out drops as soon as the grant ends or reset hits.
   assign y_out     = r_valid & data_in[r_sel];
   assign sel_out   = r_sel;
   assign grant_out = r_grant;
   assign valid_out = r_valid;

endmodule

// File: tb/tb_rr_scan4.sv
// ----------------------------------------------------------------------------
// tb_rr_scan4
//
// Directed bench for rr_scan4 with HOLD_MAX = 4. Each scenario queues the
// beats it expects the arbiter to deliver. A monitor on the falling edge pops
// one expected beat for every handshake it sees and compares sel/grant/y.
// Control behaviour (bubbles, idle, reset) is compared at fixed points from
// the stimulus thread.
// ----------------------------------------------------------------------------
module tb_rr_scan4;

   localparam int HoldMax = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] reqIn;
   logic [3:0] dataIn;
   logic       readyIn;
   logic [1:0] selOut;
   logic [3:0] grantOut;
   logic       validOut;
   logic       yOut;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] grant;
      logic       y;
   } beat_t;

   beat_t expQ[$];
   beat_t monExp;
   int    compared   = 0;
   int    mismatched = 0;

   rr_scan4 #(.HOLD_MAX(HoldMax)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (reqIn),
      .data_in   (dataIn),
      .ready_in  (readyIn),
      .sel_out   (selOut),
      .grant_out (grantOut),
      .valid_out (validOut),
      .y_out     (yOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every handshake seen mid-cycle is a beat that the next rising edge will
   // transfer. Each one must match the oldest beat the stimulus promised.
   always @(negedge clk) begin
      if (rst_n && validOut && readyIn) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL beat: got sel=%0d grant=%b y=%b, required no transfer",
                     selOut, grantOut, yOut);
         end else begin
            monExp = expQ.pop_front();
            if ({selOut, grantOut, yOut} !== monExp) begin
               mismatched++;
               $display("[TB] FAIL beat: got sel=%0d grant=%b y=%b, required sel=%0d grant=%b y=%b",
                        selOut, grantOut, yOut, monExp.sel, monExp.grant, monExp.y);
            end
         end
      end
   end

   // Stop a hung run. A hang is counted as a failure.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got no completion, required finish before 50000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] data,
                                input logic rdy);
      reqIn   = req;
      dataIn  = data;
      readyIn = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [1:0] expSel,
                              input logic [3:0] expGrant, input logic expValid,
                              input logic expY);
      compared++;
      if ({selOut, grantOut, validOut, yOut} !== {expSel, expGrant, expValid, expY}) begin
         mismatched++;
         $display("[TB] FAIL %s: got sel=%0d grant=%b valid=%b y=%b, required sel=%0d grant=%b valid=%b y=%b",
                  name, selOut, grantOut, validOut, yOut, expSel, expGrant, expValid, expY);
      end
   endtask

   task automatic pushBeats(input int n, input logic [1:0] ch, input logic y);
      beat_t b;
      b.sel   = ch;
      b.grant = 4'b0001 << ch;
      b.y     = y;
      for (int i = 0; i < n; i++) expQ.push_back(b);
   endtask

   task automatic applyReset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      #1;
      checkOutput("resetAsync", 2'd0, 4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] d;
      logic [1:0] ch;
      rst_n = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Single channel 2: ARB bubble, 4 beats, rotation, re-grant of channel 2.
      applyReset();
      applyStimulus(4'b0100, 4'b0100, 1'b1);
      pushBeats(HoldMax, 2'd2, 1'b1);
      step(1); checkOutput("s1Arb",     2'd0, 4'b0000, 1'b0, 1'b0);
      step(1); checkOutput("s1Serve",   2'd2, 4'b0100, 1'b1, 1'b1);
      step(3); checkOutput("s1Hold",    2'd2, 4'b0100, 1'b1, 1'b1);
      step(1); checkOutput("s1Rotate",  2'd2, 4'b0000, 1'b0, 1'b0);
      pushBeats(HoldMax, 2'd2, 1'b1);
      step(1); checkOutput("s1Regrant", 2'd2, 4'b0100, 1'b1, 1'b1);
      step(4); checkOutput("s1Rotate2", 2'd2, 4'b0000, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step(1); checkOutput("s1Idle",    2'd2, 4'b0000, 1'b0, 1'b0);

      // All four requesting: grants rotate 0,1,2,3,0 with one bubble between.
      applyReset();
      d = 4'b1010;
      applyStimulus(4'b1111, d, 1'b1);
      for (int g = 0; g < 5; g++) begin
         ch = 2'(g % 4);
         pushBeats(HoldMax, ch, d[ch]);
      end
      step(1); checkOutput("s2Arb", 2'd0, 4'b0000, 1'b0, 1'b0);
      for (int g = 0; g < 5; g++) begin
         ch = 2'(g % 4);
         step(1); checkOutput("s2Grant",  ch, 4'b0001 << ch, 1'b1, d[ch]);
         step(3); checkOutput("s2Held",   ch, 4'b0001 << ch, 1'b1, d[ch]);
         step(1); checkOutput("s2Bubble", ch, 4'b0000, 1'b0, 1'b0);
      end
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step(1); checkOutput("s2Idle", 2'd0, 4'b0000, 1'b0, 1'b0);

      // Channel 1 stalled for 20 cycles, then exactly 4 transfers.
      applyReset();
      applyStimulus(4'b0010, 4'b0010, 1'b0);
      step(1);  checkOutput("s3Arb",    2'd0, 4'b0000, 1'b0, 1'b0);
      step(1);  checkOutput("s3Serve",  2'd1, 4'b0010, 1'b1, 1'b1);
      step(20); checkOutput("s3Stall",  2'd1, 4'b0010, 1'b1, 1'b1);
      dataIn = 4'b0000;
      #1;       checkOutput("s3YComb",  2'd1, 4'b0010, 1'b1, 1'b0);
      dataIn = 4'b0010;
      pushBeats(HoldMax, 2'd1, 1'b1);
      readyIn = 1'b1;
      step(3);  checkOutput("s3Drain",  2'd1, 4'b0010, 1'b1, 1'b1);
      step(1);  checkOutput("s3Rotate", 2'd1, 4'b0000, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step(1);

      // Channel 3 drops its request after 2 beats; the pointer wraps to 0.
      applyReset();
      applyStimulus(4'b1000, 4'b1000, 1'b1);
      pushBeats(2, 2'd3, 1'b1);
      step(1); checkOutput("s4Arb",    2'd0, 4'b0000, 1'b0, 1'b0);
      step(1); checkOutput("s4Serve",  2'd3, 4'b1000, 1'b1, 1'b1);
      step(2); checkOutput("s4TwoBeat", 2'd3, 4'b1000, 1'b1, 1'b1);
      applyStimulus(4'b0001, 4'b1000, 1'b0);
      step(1); checkOutput("s4Drop",   2'd3, 4'b0000, 1'b0, 1'b0);
      readyIn = 1'b1;
      pushBeats(HoldMax, 2'd0, 1'b0);
      step(1); checkOutput("s4Wrap",   2'd0, 4'b0001, 1'b1, 1'b0);
      step(4); checkOutput("s4Done",   2'd0, 4'b0000, 1'b0, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step(1);

      // Reset pulsed mid-serve between edges, then a search restarts at 0.
      applyReset();
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      pushBeats(2, 2'd0, 1'b1);
      step(2); checkOutput("s5Serve",    2'd0, 4'b0001, 1'b1, 1'b1);
      step(2);
      #1;
      rst_n  = 1'b0;
      reqIn  = 4'b1010;
      dataIn = 4'b1010;
      #1;      checkOutput("s5AsyncRst", 2'd0, 4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1); checkOutput("s5Arb",      2'd0, 4'b0000, 1'b0, 1'b0);
      step(1); checkOutput("s5Grant1",   2'd1, 4'b0010, 1'b1, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step(1); checkOutput("s5Exit",     2'd1, 4'b0000, 1'b0, 1'b0);
      step(1);

      // Drop and transfer on the same edge; the pointer then sits at 2.
      // ARB with no request returns to IDLE and keeps the pointer at 3.
      applyReset();
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      pushBeats(2, 2'd1, 1'b0);
      step(2); checkOutput("s6Serve",    2'd1, 4'b0010, 1'b1, 1'b0);
      step(1);
      reqIn = 4'b0000;
      step(1); checkOutput("s6DropXfer", 2'd1, 4'b0000, 1'b0, 1'b0);
      reqIn = 4'b1111;
      step(1); checkOutput("s6Ptr2",     2'd2, 4'b0100, 1'b1, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step(1); checkOutput("s6Arb",      2'd2, 4'b0000, 1'b0, 1'b0);
      step(1); checkOutput("s6ArbIdle",  2'd2, 4'b0000, 1'b0, 1'b0);
      reqIn = 4'b1111;
      step(2); checkOutput("s6Ptr3",     2'd3, 4'b1000, 1'b1, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      step(2);

      // Every promised beat must have been delivered.
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL beatsLeft: got %0d undelivered beats, required 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
